// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//  - loader FSM state encoding and its width
//  - default geometry of the instruction memory
//  - legal program-length check used when a load is requested
package inst_mem_loader_pkg;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned DEF_IMEM_ADDR_W = 10;
    localparam int unsigned DEF_INST_W      = 32;
    // Deepest program the default-size memory can hold.
    localparam int unsigned MAX_INST        = 2 ** DEF_IMEM_ADDR_W;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StArmed = 3'd2,
        StStart = 3'd3,
        StRun   = 3'd4
    } loader_state_e;

    // A program must hold at least one word and must fit in 2**addr_w words.
    function automatic logic count_is_legal(input logic [31:0] cnt, input int unsigned addr_w);
        return (cnt != 32'd0) && (cnt <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Host write stream and decoder read port of the instruction memory.
//  master: host/decoder side  - drives inst_wr_v/inst_wr_data and imem_read_req/imem_read_addr
//  slave : loader side        - drives inst_wr_ready and imem_read_data
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = DEF_IMEM_ADDR_W,
    parameter int unsigned INST_W      = DEF_INST_W
);

    logic                   inst_wr_v;
    logic [INST_W-1:0]      inst_wr_data;
    logic                   inst_wr_ready;
    logic                   imem_read_req;
    logic [IMEM_ADDR_W-1:0] imem_read_addr;
    logic [INST_W-1:0]      imem_read_data;

    modport master (
        output inst_wr_v,
        output inst_wr_data,
        input  inst_wr_ready,
        output imem_read_req,
        output imem_read_addr,
        input  imem_read_data
    );

    modport slave (
        input  inst_wr_v,
        input  inst_wr_data,
        output inst_wr_ready,
        input  imem_read_req,
        input  imem_read_addr,
        output imem_read_data
    );

endinterface

// File: rtl/inst_mem_loader_ram.sv
// inst_mem_ram: 1R1W synchronous RAM, DATA_W x 2**ADDR_W.
//  Registered read output, read-before-write on an address collision, no reset.
//  Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata read data
//  (valid one cycle after re, holds while re is low).
module inst_mem_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Sampled on the same edge as the write, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: owns the controller instruction memory.
//  Loads a host instruction stream into a local RAM, serves the decoder read port
//  (1-cycle latency) and sequences decoder start / done so a program can be rerun
//  or replaced.
// Ports:
//  clk, reset                  single clock; asynchronous active-high reset
//  cfg_load_v/cfg_num_inst/    load request, word count, auto-start flag and
//  cfg_auto_start/cfg_checksum expected XOR of the program
//  cfg_run_v                   rerun an already-loaded program
//  bus (slave)                 host write stream + decoder read port
//  decoder_start/decoder_done  decoder handshake
//  busy, load_done, load_err,  status: busy outside IDLE/ARMED, 1-cycle result
//  loaded_count                pulses, words written in the current/last load
// Build option: define INST_MEM_CHECKSUM_EN to verify cfg_checksum against the XOR
// of the loaded words; a mismatch fails the load back to IDLE.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = DEF_IMEM_ADDR_W,
    parameter int unsigned INST_W      = DEF_INST_W,
    parameter int unsigned CNT_W       = IMEM_ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load_v,
    input  logic [CNT_W-1:0]  cfg_num_inst,
    input  logic              cfg_auto_start,
    input  logic [INST_W-1:0] cfg_checksum,
    input  logic              cfg_run_v,
    inst_mem_loader_if.slave  bus,
    output logic              decoder_start,
    input  logic              decoder_done,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  loaded_count
);

    loader_state_e          state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       loaded_count_q, loaded_count_d;
    logic                   auto_start_q, auto_start_d;
    logic [IMEM_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic                   load_done_q, load_done_d;
    logic                   load_err_q, load_err_d;
    logic                   decoder_start_q, decoder_start_d;
    logic                   rd_valid_q;
    logic [INST_W-1:0]      ram_rdata;

    logic cfg_legal;
    logic load_open;
    logic load_accept;
    logic wr_fire;
    logic last_word;
    logic csum_ok;

    assign cfg_legal   = count_is_legal(32'(cfg_num_inst), IMEM_ADDR_W);
    assign load_open   = (state_q == StIdle) || (state_q == StArmed);
    assign load_accept = cfg_load_v && cfg_legal && load_open;
    assign wr_fire     = (state_q == StLoad) && bus.inst_wr_v;
    assign last_word   = (loaded_count_q + CNT_W'(1)) == count_q;

`ifdef INST_MEM_CHECKSUM_EN
    logic [INST_W-1:0] acc_q;
    logic [INST_W-1:0] checksum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else if (load_accept) begin
            acc_q      <= '0;
            checksum_q <= cfg_checksum;
        end else if (wr_fire) begin
            acc_q      <= acc_q ^ bus.inst_wr_data;
        end
    end

    // Include the word being accepted so the verdict is ready on the last write.
    assign csum_ok = (acc_q ^ bus.inst_wr_data) == checksum_q;
`else
    logic unused_checksum;
    assign unused_checksum = ^cfg_checksum;
    assign csum_ok         = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        auto_start_d    = auto_start_q;
        wr_ptr_d        = wr_ptr_q;
        loaded_count_d  = loaded_count_q;
        load_done_d     = 1'b0;
        load_err_d      = 1'b0;
        decoder_start_d = 1'b0;

        if (load_accept) begin
            count_d        = cfg_num_inst;
            auto_start_d   = cfg_auto_start;
            wr_ptr_d       = '0;
            loaded_count_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (cfg_load_v) begin
                    if (cfg_legal) state_d = StLoad;
                    else           load_err_d = 1'b1;
                end
            end
            StArmed: begin
                // A load request takes priority over a simultaneous run request.
                if (cfg_load_v) begin
                    if (cfg_legal) state_d = StLoad;
                    else           load_err_d = 1'b1;
                end else if (cfg_run_v) begin
                    state_d = StStart;
                end
            end
            StLoad: begin
                if (wr_fire) begin
                    wr_ptr_d       = wr_ptr_q + IMEM_ADDR_W'(1);
                    loaded_count_d = loaded_count_q + CNT_W'(1);
                    if (last_word) begin
                        if (csum_ok) begin
                            load_done_d = 1'b1;
                            state_d     = auto_start_q ? StStart : StArmed;
                        end else begin
                            load_err_d = 1'b1;
                            state_d    = StIdle;
                        end
                    end
                end
            end
            StStart: begin
                decoder_start_d = 1'b1;
                state_d         = StRun;
            end
            StRun: begin
                if (decoder_done) state_d = StArmed;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            count_q         <= '0;
            auto_start_q    <= 1'b0;
            wr_ptr_q        <= '0;
            loaded_count_q  <= '0;
            load_done_q     <= 1'b0;
            load_err_q      <= 1'b0;
            decoder_start_q <= 1'b0;
            rd_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            auto_start_q    <= auto_start_d;
            wr_ptr_q        <= wr_ptr_d;
            loaded_count_q  <= loaded_count_d;
            load_done_q     <= load_done_d;
            load_err_q      <= load_err_d;
            decoder_start_q <= decoder_start_d;
            if (bus.imem_read_req) rd_valid_q <= 1'b1;
        end
    end

    inst_mem_ram #(
        .ADDR_W (IMEM_ADDR_W),
        .DATA_W (INST_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (bus.inst_wr_data),
        .re    (bus.imem_read_req),
        .raddr (bus.imem_read_addr),
        .rdata (ram_rdata)
    );

    // RAM read register has no reset; mask it until the first read after reset.
    assign bus.imem_read_data = rd_valid_q ? ram_rdata : '0;
    assign bus.inst_wr_ready  = (state_q == StLoad);
    assign busy               = !load_open;
    assign load_done          = load_done_q;
    assign load_err           = load_err_q;
    assign decoder_start      = decoder_start_q;
    assign loaded_count       = loaded_count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: random program data, expected memory
// contents kept in a reference array, cycle timing taken from the block's rules.
module tb_inst_mem_loader;
    import inst_mem_loader_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned IW    = 32;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_load_v;
    logic [CW-1:0] cfg_num_inst;
    logic          cfg_auto_start;
    logic [IW-1:0] cfg_checksum;
    logic          cfg_run_v;
    logic          decoder_start;
    logic          decoder_done;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic [CW-1:0] loaded_count;

    inst_mem_loader_if #(.IMEM_ADDR_W(AW), .INST_W(IW)) bus ();

    inst_mem_loader #(
        .IMEM_ADDR_W (AW),
        .INST_W      (IW),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_load_v     (cfg_load_v),
        .cfg_num_inst   (cfg_num_inst),
        .cfg_auto_start (cfg_auto_start),
        .cfg_checksum   (cfg_checksum),
        .cfg_run_v      (cfg_run_v),
        .bus            (bus),
        .decoder_start  (decoder_start),
        .decoder_done   (decoder_done),
        .busy           (busy),
        .load_done      (load_done),
        .load_err       (load_err),
        .loaded_count   (loaded_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [IW-1:0] ref_mem [DEPTH];
    logic [IW-1:0] q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] xor_of(input logic [IW-1:0] w[$]);
        logic [IW-1:0] x = '0;
        foreach (w[i]) x ^= w[i];
        return x;
    endfunction

    task automatic check_outs(input string tag, input bit e_ready, input bit e_busy,
                              input bit e_done, input bit e_err, input bit e_start);
        check({tag, ".ready"}, 64'(bus.inst_wr_ready), 64'(e_ready));
        check({tag, ".busy"},  64'(busy),              64'(e_busy));
        check({tag, ".done"},  64'(load_done),         64'(e_done));
        check({tag, ".err"},   64'(load_err),          64'(e_err));
        check({tag, ".start"}, 64'(decoder_start),     64'(e_start));
    endtask

    task automatic clear_inputs();
        cfg_load_v         = 1'b0;
        cfg_num_inst       = '0;
        cfg_auto_start     = 1'b0;
        cfg_checksum       = '0;
        cfg_run_v          = 1'b0;
        decoder_done       = 1'b0;
        bus.inst_wr_v      = 1'b0;
        bus.inst_wr_data   = '0;
        bus.imem_read_req  = 1'b0;
        bus.imem_read_addr = '0;
    endtask

    // Reset is applied between edges; outputs must clear without waiting for a clock.
    task automatic apply_reset(input string tag);
        clear_inputs();
        reset = 1'b1;
        #1;
        check_outs({tag, ".rst"}, 0, 0, 0, 0, 0);
        check({tag, ".rst.count"}, 64'(loaded_count), 64'd0);
        check({tag, ".rst.rdata"}, 64'(bus.imem_read_data), 64'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_load(input int n, input bit auto_start, input logic [IW-1:0] csum);
        cfg_load_v     = 1'b1;
        cfg_num_inst   = CW'(n);
        cfg_auto_start = auto_start;
        cfg_checksum   = csum;
        tick();
        cfg_load_v     = 1'b0;
    endtask

    task automatic pulse_run();
        cfg_run_v = 1'b1;
        tick();
        cfg_run_v = 1'b0;
    endtask

    task automatic pulse_done();
        decoder_done = 1'b1;
        tick();
        decoder_done = 1'b0;
    endtask

    // Words w[first..last-1] go to addresses first..last-1, with random idle gaps.
    task automatic send_words(input logic [IW-1:0] w[$], input int gap_max,
                              input int first, input int last);
        for (int i = first; i < last; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                bus.inst_wr_data = $urandom;
                tick();
            end
            bus.inst_wr_v    = 1'b1;
            bus.inst_wr_data = w[i];
            ref_mem[i]       = w[i];
            tick();
            bus.inst_wr_v    = 1'b0;
        end
    endtask

    task automatic read_check(input string tag, input int a);
        bus.imem_read_req  = 1'b1;
        bus.imem_read_addr = AW'(a);
        tick();
        bus.imem_read_req  = 1'b0;
        check(tag, 64'(bus.imem_read_data), 64'(ref_mem[a]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] old0;
        logic [IW-1:0] last_rd;

        clear_inputs();
        reset = 1'b1;
        #1;
        check_outs("t0", 0, 0, 0, 0, 0);
        check("t0.count", 64'(loaded_count), 64'd0);
        check("t0.rdata", 64'(bus.imem_read_data), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: four fixed words, auto start.
        q = {32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004};
        pulse_load(4, 1'b1, xor_of(q));
        check_outs("t1.load", 1, 1, 0, 0, 0);
        send_words(q, 0, 0, 4);
        check_outs("t1.last", 0, 1, 1, 0, 0);
        check("t1.count", 64'(loaded_count), 64'd4);
        tick();
        check_outs("t1.start", 0, 1, 0, 0, 1);
        tick();
        check_outs("t1.run", 0, 1, 0, 0, 0);
        pulse_done();
        check_outs("t1.armed", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) read_check($sformatf("t1.rd%0d", i), i);
        last_rd = ref_mem[3];
        tick();
        check("t1.hold", 64'(bus.imem_read_data), 64'(last_rd));

        // 2: illegal counts, first while ARMED, then from IDLE.
        pulse_load(0, 1'b1, '0);
        check_outs("t2.armed0", 0, 0, 0, 1, 0);
        check("t2.keepcnt", 64'(loaded_count), 64'd4);
        pulse_load(int'(MAX_INST) + 1, 1'b1, '0);
        check_outs("t2.armed1025", 0, 0, 0, 1, 0);
        apply_reset("t2");
        pulse_load(0, 1'b0, '0);
        check_outs("t2.idle0", 0, 0, 0, 1, 0);
        pulse_load(DEPTH + 1, 1'b0, '0);
        check_outs("t2.idle1025", 0, 0, 0, 1, 0);
        tick();
        check_outs("t2.after", 0, 0, 0, 0, 0);
        pulse_run();
        tick();
        check_outs("t2.runidle", 0, 0, 0, 0, 0);

        // 3: full-depth random program with gaps, manual start, rerun.
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
        pulse_load(DEPTH, 1'b0, xor_of(q));
        send_words(q, 2, 0, DEPTH);
        check_outs("t3.last", 0, 0, 1, 0, 0);
        check("t3.count", 64'(loaded_count), 64'(DEPTH));
        tick();
        check_outs("t3.armed", 0, 0, 0, 0, 0);
        pulse_run();
        check_outs("t3.startst", 0, 1, 0, 0, 0);
        tick();
        check_outs("t3.start", 0, 1, 0, 0, 1);
        tick();
        pulse_done();
        check_outs("t3.rearmed", 0, 0, 0, 0, 0);
        pulse_run();
        tick();
        check_outs("t3.start2", 0, 1, 0, 0, 1);
        pulse_done();
        // Writes outside LOAD must not land anywhere.
        bus.inst_wr_v    = 1'b1;
        bus.inst_wr_data = ~ref_mem[0];
        tick();
        check("t3.nowr.ready", 64'(bus.inst_wr_ready), 64'd0);
        tick();
        bus.inst_wr_v = 1'b0;
        read_check("t3.nowr.rd0", 0);
        for (int k = 0; k < 12; k++) begin
            int a;
            a = int'($urandom_range(DEPTH - 1, 0));
            read_check($sformatf("t3.rd@%0d", a), a);
        end

        // 4: reset after 2 of 8 words; partial data stays in the RAM.
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back($urandom);
        pulse_load(8, 1'b0, xor_of(q));
        send_words(q, 1, 0, 2);
        check_outs("t4.mid", 1, 1, 0, 0, 0);
        apply_reset("t4");
        pulse_run();
        tick();
        check_outs("t4.norun", 0, 0, 0, 0, 0);
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back($urandom);
        pulse_load(8, 1'b0, xor_of(q));
        // First write collides with a read of the same address: old data expected.
        old0               = ref_mem[0];
        bus.inst_wr_v      = 1'b1;
        bus.inst_wr_data   = q[0];
        bus.imem_read_req  = 1'b1;
        bus.imem_read_addr = '0;
        tick();
        bus.inst_wr_v      = 1'b0;
        bus.imem_read_req  = 1'b0;
        ref_mem[0]         = q[0];
        check("t4.rbw", 64'(bus.imem_read_data), 64'(old0));
        send_words(q, 1, 1, 8);
        check_outs("t4.last", 0, 0, 1, 0, 0);
        check("t4.count", 64'(loaded_count), 64'd8);
        for (int i = 0; i < 8; i++) read_check($sformatf("t4.rd%0d", i), i);

        // 5: requests during RUN are ignored; load beats run in ARMED.
        pulse_run();
        tick();
        check_outs("t5.run", 0, 1, 0, 0, 1);
        pulse_load(4, 1'b1, '0);
        check_outs("t5.ign", 0, 1, 0, 0, 0);
        tick();
        check_outs("t5.ign2", 0, 1, 0, 0, 0);
        pulse_done();
        check_outs("t5.armed", 0, 0, 0, 0, 0);
        q.delete();
        for (int i = 0; i < 2; i++) q.push_back($urandom);
        cfg_run_v = 1'b1;
        pulse_load(2, 1'b0, xor_of(q));
        cfg_run_v = 1'b0;
        check_outs("t5.both", 1, 1, 0, 0, 0);
        tick();
        check_outs("t5.both2", 1, 1, 0, 0, 0);
        send_words(q, 0, 0, 2);
        check_outs("t5.last", 0, 0, 1, 0, 0);
        tick();
        check_outs("t5.nostart", 0, 0, 0, 0, 0);
        // Reset while running: a later done must not restart anything.
        pulse_run();
        tick();
        apply_reset("t5r");
        pulse_done();
        check_outs("t5r.done", 0, 0, 0, 0, 0);
        tick();
        check_outs("t5r.done2", 0, 0, 0, 0, 0);

        // 6: checksum pair {0xA, 0x5}: 0xF is the true XOR, 0xE is wrong.
        q = {32'h0000_000A, 32'h0000_0005};
        pulse_load(2, 1'b1, 32'h0000_000F);
        send_words(q, 0, 0, 2);
        check_outs("t6.good", 0, 1, 1, 0, 0);
        tick();
        check_outs("t6.goodstart", 0, 1, 0, 0, 1);
        pulse_done();
        pulse_load(2, 1'b1, 32'h0000_000E);
        send_words(q, 0, 0, 2);
`ifdef INST_MEM_CHECKSUM_EN
        check_outs("t6.bad", 0, 0, 0, 1, 0);
        tick();
        check_outs("t6.badidle", 0, 0, 0, 0, 0);
        pulse_run();
        tick();
        check_outs("t6.badnorun", 0, 0, 0, 0, 0);
`else
        check_outs("t6.ignored", 0, 1, 1, 0, 0);
        tick();
        check_outs("t6.ignstart", 0, 1, 0, 0, 1);
        pulse_done();
`endif
        read_check("t6.rd0", 0);
        read_check("t6.rd1", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
